// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
// Latency: n/a (declarations only).
// Backpressure: n/a; the target never stretches SCL.
package i2c_target_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_ACK    = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the async SCL/SDA levels and flags SCL edges and START/STOP conditions.
// Latency: event pulses appear 2-3 clk_i after the bus transition.
// Backpressure: none; pulses are single-cycle and unconditional.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_sync_o
);

    // [0] first sync stage, [1] synchronised level, [2] previous synchronised level
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    // Shift each bus line through its synchroniser/edge-history chain
    always_comb begin
        scl_d = {scl_q[1:0], scl_i};
        sda_d = {sda_q[1:0], sda_i};
    end

    // History resets to an idle (released) bus so reset release creates no false events
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & ~sda_q[2] & sda_q[1];
    assign sda_sync_o = sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: pointer write, data write, sequential read.
// Latency: SDA drive changes one clk_i after a detected SCL fall; writes strobe one clk_i after the 8th rise.
// Backpressure: never stretches SCL; START/STOP override any bit activity.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TargetAddr  = 7'h50,
    parameter int         NumRegs     = 16,
    parameter logic [7:0] RegResetVal = 8'h00,
    localparam int        PW          = $clog2(NumRegs)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oe_o,
    output logic          busy_o,
    output logic          wr_valid_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o
);

    logic scl_rise, scl_fall, start, stop, sda_sync;

    i2c_bus_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_sync_o (sda_sync)
    );

    i2c_tgt_state_e        state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  first_q, first_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [PW-1:0]         wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            regs_q [NumRegs];
    logic [7:0]            regs_d [NumRegs];
    logic [7:0]            rx_byte;

    // Next-state logic: bus conditions first, then per-state bit handling on SCL edges
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        first_d    = first_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        rx_byte    = {shift_q[6:0], sda_sync};

        if (stop) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start) begin
            state_d   = ADDR;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        // general call (address 0) is never acknowledged
                        if (rx_byte[7:1] == TargetAddr && rx_byte[7:1] != 7'h00) begin
                            state_d = ADDR_ACK;
                            first_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // oe_q distinguishes the fall that starts the ACK from the one that ends it
                ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else if (shift_q[0]) begin
                        state_d = RD_BYTE;
                        shift_d = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                    end else begin
                        state_d = WR_BYTE;
                        oe_d    = 1'b0;
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d = rx_byte;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = WR_ACK;
                        if (first_q) begin
                            first_d = 1'b0;
                            ptr_d   = rx_byte[PW-1:0];
                        end else begin
                            regs_d[ptr_q] = rx_byte;
                            wr_valid_d    = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = rx_byte;
                            ptr_d         = ptr_q + PW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = WR_BYTE;
                    end
                end
                // shift_q[7] is always the bit currently on the bus
                RD_BYTE: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        oe_d      = 1'b0;
                        state_d   = RD_ACK;
                        bit_cnt_d = 3'd0;
                        ptr_d     = ptr_q + PW'(1);
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        oe_d      = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // bit_cnt_q==1 marks a host ACK seen, next byte loads on the following fall
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync == I2C_ACK) bit_cnt_d = 3'd1;
                        else                     state_d   = WAIT_STOP;
                    end else if (scl_fall && bit_cnt_q == 3'd1) begin
                        state_d   = RD_BYTE;
                        bit_cnt_d = 3'd0;
                        shift_d   = regs_q[ptr_q];
                        oe_d      = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset releases SDA immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= RegResetVal;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign sda_o      = 1'b0;
    assign sda_oe_o   = oe_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench: acts as I2C host at clk/16 on a wired-AND bus, against a transaction-level model.
// Latency: model expectations are per bus transaction, write strobes matched in order.
// Backpressure: n/a.
module tb_i2c_target_regfile;

    localparam int NUM = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_scl = 1'b1;
    logic       host_sda = 1'b1;
    logic       sda_bus;
    logic       sda_o, sda_oe_o, busy_o, wr_valid_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;

    assign sda_bus = host_sda & (sda_oe_o ? sda_o : 1'b1);

    i2c_target_regfile dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (host_scl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .sda_oe_o   (sda_oe_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // transaction-level model
    logic [7:0]  m_regs [NUM];
    int          m_ptr = 0;
    bit          m_sel = 0;
    bit          m_rw = 0;
    bit          m_first = 0;
    bit          expect_silent = 0;
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];
    logic [11:0] cmp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // compare process: every write strobe against the model's expected-write queue
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid_o) begin
                obs_q.push_back({wr_addr_o, wr_data_o});
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL wr_strobe_unexpected: got addr %0h data %0h expected no write",
                             wr_addr_o, wr_data_o);
                end else begin
                    cmp_e = exp_q.pop_front();
                    chk("wr_strobe", {wr_addr_o, wr_data_o}, cmp_e);
                end
            end
            if (expect_silent) chk("silent_oe", sda_oe_o, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        tick(4); host_sda = b; tick(4); host_scl = 1'b1; tick(8); host_scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        tick(4); host_sda = 1'b1; tick(4); host_scl = 1'b1; tick(4); b = sda_bus; tick(4); host_scl = 1'b0;
    endtask

    task automatic host_start();
        tick(4); host_sda = 1'b1; tick(4); host_scl = 1'b1; tick(4); host_sda = 1'b0; tick(4); host_scl = 1'b0;
        m_sel = 0;
        chk("busy_after_start", busy_o, 1);
    endtask

    task automatic host_stop();
        tick(4); host_sda = 1'b0; tick(4); host_scl = 1'b1; tick(4); host_sda = 1'b1; tick(8);
        m_sel = 0;
        chk("busy_after_stop", busy_o, 0);
    endtask

    task automatic host_byte(input logic [7:0] b, input bit exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(a);
        chk("ack_bit", a, exp_ack ? 0 : 1);
    endtask

    task automatic host_addr(input logic [6:0] a7, input bit rw);
        m_sel   = (a7 == 7'h50);
        m_rw    = rw;
        m_first = 1;
        host_byte({a7, rw}, m_sel);
    endtask

    task automatic host_wr(input logic [7:0] b);
        bit acc;
        acc = m_sel && !m_rw;
        if (acc) begin
            if (m_first) begin
                m_ptr   = b % NUM;
                m_first = 0;
            end else begin
                exp_q.push_back({4'(m_ptr), b});
                m_regs[m_ptr] = b;
                m_ptr = (m_ptr + 1) % NUM;
            end
        end
        host_byte(b, acc);
    endtask

    task automatic host_rd(input logic ack, output logic [7:0] b);
        logic [7:0] exp;
        logic       x;
        exp   = m_regs[m_ptr];
        m_ptr = (m_ptr + 1) % NUM;
        for (int i = 7; i >= 0; i--) begin
            bit_in(x);
            b[i] = x;
        end
        chk("rd_data", b, exp);
        tick(4); host_sda = ack; tick(4); host_scl = 1'b1; tick(4);
        chk("sda_released_on_host_ack", sda_oe_o, 0);
        tick(4); host_scl = 1'b0;
        if (ack) m_sel = 0;
    endtask

    task automatic write_txn(input logic [7:0] reg_i, input logic [7:0] d0, input logic [7:0] d1, input int n);
        host_start();
        host_addr(7'h50, 0);
        host_wr(reg_i);
        if (n > 0) host_wr(d0);
        if (n > 1) host_wr(d1);
        host_stop();
    endtask

    task automatic read_txn(input logic [7:0] reg_i, input int n, output logic [7:0] first_b, output logic [7:0] last_b);
        logic [7:0] b;
        host_start();
        host_addr(7'h50, 0);
        host_wr(reg_i);
        host_start();
        host_addr(7'h50, 1);
        first_b = 8'h00;
        for (int i = 0; i < n; i++) begin
            host_rd((i == n - 1) ? 1'b1 : 1'b0, b);
            if (i == 0) first_b = b;
        end
        last_b = b;
        host_stop();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b0, b1;
        int kind, n, nobs;
        logic [6:0] bad;

        for (int i = 0; i < NUM; i++) m_regs[i] = 8'h00;
        tick(3);
        chk("reset_oe", sda_oe_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_wr_valid", wr_valid_o, 0);
        chk("reset_wr_addr", wr_addr_o, 0);
        chk("reset_wr_data", wr_data_o, 0);
        rst = 1'b0;
        tick(4);

        // basic write of two bytes from pointer 3
        write_txn(8'h03, 8'hA5, 8'h5A, 2);
        tick(4);
        chk("obs_count_s1", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("obs_first_write", obs_q[0], 12'h3A5);
            chk("obs_second_write", obs_q[1], 12'h45A);
        end

        // pointer write, repeated start, read ACK then NACK
        read_txn(8'h03, 2, b0, b1);
        chk("read_lit_A5", b0, 8'hA5);
        chk("read_lit_5A", b1, 8'h5A);

        // address mismatch: target stays off the bus, data is ignored
        nobs = obs_q.size();
        expect_silent = 1;
        host_start();
        host_addr(7'h51, 0);
        host_wr(8'h77);
        host_stop();
        expect_silent = 0;
        chk("mismatch_no_write", obs_q.size(), nobs);

        // pointer wrap from the last register
        write_txn(8'h0F, 8'h11, 8'h22, 2);
        read_txn(8'h0F, 2, b0, b1);
        chk("wrap_lit_reg15", b0, 8'h11);
        chk("wrap_lit_reg0", b1, 8'h22);

        // STOP in the middle of a data byte: nothing committed
        nobs = obs_q.size();
        host_start();
        host_addr(7'h50, 0);
        host_wr(8'h06);
        bit_out(1'b1); bit_out(1'b1); bit_out(1'b0); bit_out(1'b0);
        host_stop();
        tick(8);
        chk("partial_no_write", obs_q.size(), nobs);
        write_txn(8'h03, 8'hA5, 8'h5A, 2);
        read_txn(8'h06, 1, b0, b1);
        chk("partial_reg6_lit", b0, 8'h00);

        // randomized traffic
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            if (kind <= 1) begin
                write_txn(8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom), (n > 2) ? 2 : n);
            end else if (kind == 2) begin
                read_txn(8'($urandom_range(0, NUM - 1)), n, b0, b1);
            end else begin
                bad = 7'($urandom_range(0, 127));
                if (bad == 7'h50) bad = 7'h00;
                expect_silent = 1;
                host_start();
                host_addr(bad, 1'($urandom_range(0, 1)));
                host_wr(8'($urandom));
                host_stop();
                expect_silent = 0;
            end
        end

        // reset while the target is driving a 0 data bit
        write_txn(8'h05, 8'h3C, 8'h00, 1);
        host_start();
        host_addr(7'h50, 0);
        host_wr(8'h05);
        host_start();
        host_addr(7'h50, 1);
        tick(8);
        chk("rd_bit7_driven_low", sda_oe_o, 1);
        #2 rst = 1'b1;
        #1 chk("oe_async_reset", sda_oe_o, 0);
        chk("busy_async_reset", busy_o, 0);
        for (int i = 0; i < NUM; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        m_sel = 0;
        exp_q.delete();
        tick(3);
        host_scl = 1'b1;
        host_sda = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(8);
        read_txn(8'h05, 1, b0, b1);
        chk("reg5_after_reset_lit", b0, 8'h00);
        read_txn(8'h00, 4, b0, b1);

        tick(8);
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
